mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 148 ++++++++++++++
 tb/tb_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: assembles little-endian byte streams into NB_DATA-bit words and
// writes them to consecutive memory addresses until a terminator word is seen
// or the address range is exhausted.
module mem_loader #(
    parameter int                 NB_DATA    = 32,
    parameter int                 N_ADDRESS  = 64,
    parameter int                 NB_ADDRESS = $clog2(N_ADDRESS),
    parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_DATA-1:0]    o_w_data,
    output logic [NB_ADDRESS-1:0] o_w_addr,
    output logic                  o_w_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_full,
    output logic [NB_ADDRESS:0]   o_word_count
);

    // Highest writable address; the address counter saturates here.
    localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);
    localparam logic [NB_ADDRESS-1:0] ADDR_ONE  = NB_ADDRESS'(1);
    localparam logic [NB_ADDRESS:0]   CNT_ONE   = (NB_ADDRESS + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    start_load;

    // Byte lane pointer and partially assembled word.
    logic [1:0]              byte_cnt;
    logic [NB_DATA-1:0]      word_p0;
    logic [NB_DATA-1:0]      asm_word;
    logic                    capture;
    logic                    word_complete;

    // Address of the next word to be written.
    logic [NB_ADDRESS-1:0]   addr;

    // Termination conditions evaluated on the word currently being written.
    logic                    halt_hit;
    logic                    last_hit;

    assign capture       = (state == LOAD) && i_rx_valid;
    assign word_complete = capture && (byte_cnt == 2'd3);
    assign halt_hit      = o_w_en && (o_w_data == HALT_WORD);
    assign last_hit      = o_w_en && (o_w_addr == LAST_ADDR);

    // Merge the incoming byte into its lane of the partially assembled word.
    always_comb begin
        asm_word = word_p0;
        asm_word[{byte_cnt, 3'b000} +: 8] = i_rx_data;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        next_state = state;
        start_load = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                o_busy = 1'b1;
                // The load ends on the edge that closes the write cycle, so
                // o_busy stays high while the final word is presented.
                if (halt_hit || last_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte assembly, write-port register, address and word counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt     <= 2'd0;
            word_p0      <= '0;
            addr         <= '0;
            o_w_data     <= '0;
            o_w_addr     <= '0;
            o_w_en       <= 1'b0;
            o_word_count <= '0;
            o_full       <= 1'b0;
        end else begin
            o_w_en <= 1'b0;
            if (start_load) begin
                // A byte arriving with the start request is deliberately dropped.
                byte_cnt     <= 2'd0;
                addr         <= '0;
                o_word_count <= '0;
                o_full       <= 1'b0;
            end else begin
                if (capture) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    word_p0  <= asm_word;
                end
                if (word_complete) begin
                    o_w_data     <= asm_word;
                    o_w_addr     <= addr;
                    o_w_en       <= 1'b1;
                    o_word_count <= o_word_count + CNT_ONE;
                    if (addr != LAST_ADDR) begin
                        addr <= addr + ADDR_ONE;
                    end
                end
                // Terminator has precedence over the address limit.
                if (last_hit && !halt_hit) begin
                    o_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized and directed stimulus for mem_loader, checked
// against a transaction-level model of the load protocol.
module tb_mem_loader;

    localparam int          NB_DATA    = 32;
    localparam int          N_ADDRESS  = 64;
    localparam int          NB_ADDRESS = 6;
    localparam logic [31:0] HALT       = 32'hFFFFFFFF;

    logic                  i_clk = 1'b0;
    logic                  i_reset = 1'b0;
    logic                  i_start = 1'b0;
    logic [7:0]            i_rx_data = 8'h00;
    logic                  i_rx_valid = 1'b0;
    logic [NB_DATA-1:0]    o_w_data;
    logic [NB_ADDRESS-1:0] o_w_addr;
    logic                  o_w_en;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_full;
    logic [NB_ADDRESS:0]   o_word_count;

    mem_loader #(
        .NB_DATA   (NB_DATA),
        .N_ADDRESS (N_ADDRESS),
        .NB_ADDRESS(NB_ADDRESS),
        .HALT_WORD (HALT)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_w_data    (o_w_data),
        .o_w_addr    (o_w_addr),
        .o_w_en      (o_w_en),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_full      (o_full),
        .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level model of the loader.
    bit          m_loading = 0;
    bit          m_ending  = 0;
    bit          m_done    = 0;
    bit          m_full    = 0;
    int          m_addr    = 0;
    int          m_count   = 0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_last_data = 0;
    int          m_last_addr = 0;
    int          exp_writes  = 0;
    int          seen_writes = 0;

    always @(negedge i_clk) begin
        if (o_w_en === 1'b1) seen_writes++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts whether a write must appear.
    task automatic drive_cycle(input bit rst, input bit s, input bit v, input logic [7:0] b);
        bit          exp_w;
        logic [31:0] w;
        exp_w = 0;
        w     = 0;
        i_reset = rst; i_start = s; i_rx_valid = v; i_rx_data = b;
        if (rst) begin
            m_loading = 0; m_ending = 0; m_done = 0; m_full = 0;
            m_addr = 0; m_count = 0; m_bytes.delete();
            m_last_data = 0; m_last_addr = 0;
        end else if (m_ending) begin
            // Final write cycle: start and bytes have no lasting effect.
            m_ending = 0;
        end else if (!m_loading) begin
            if (s) begin
                m_loading = 1; m_done = 0; m_full = 0;
                m_addr = 0; m_count = 0; m_bytes.delete();
            end
        end else if (v) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_bytes.delete();
                exp_w = 1;
                exp_writes++;
                m_count++;
                m_last_data = w;
                m_last_addr = m_addr;
                if (w == HALT) begin
                    m_loading = 0; m_ending = 1; m_done = 1; m_full = 0;
                end else if (m_addr == N_ADDRESS - 1) begin
                    m_loading = 0; m_ending = 1; m_done = 1; m_full = 1;
                end else begin
                    m_addr++;
                end
            end
        end
        @(posedge i_clk);
        #1;
        i_reset = 0; i_start = 0; i_rx_valid = 0;
        if (exp_w) begin
            check("wen", 64'(o_w_en), 64'd1);
            check("wdata", 64'(o_w_data), 64'(m_last_data));
            check("waddr", 64'(o_w_addr), 64'(m_last_addr));
            check("wcount", 64'(o_word_count), 64'(m_count));
            check("wbusy", 64'(o_busy), 64'd1);
        end else begin
            check("no_wen", 64'(o_w_en), 64'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_cycle(0, 0, 1, b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if ($urandom_range(0, 3) == 0) drive_cycle(0, 0, 0, 8'h00);
        end
    endtask

    task automatic do_start(input bit with_byte);
        drive_cycle(0, 0, 0, 8'h00);
        drive_cycle(0, 1, with_byte, 8'($urandom));
    endtask

    task automatic check_status(input string tag);
        drive_cycle(0, 0, 0, 8'h00);
        check({tag, "_done"}, 64'(o_done), 64'(m_done));
        check({tag, "_busy"}, 64'(o_busy), 64'(m_loading));
        check({tag, "_full"}, 64'(o_full), 64'(m_full));
        check({tag, "_count"}, 64'(o_word_count), 64'(m_count));
        check({tag, "_data"}, 64'(o_w_data), 64'(m_last_data));
        check({tag, "_addr"}, 64'(o_w_addr), 64'(m_last_addr));
        check({tag, "_nwr"}, 64'(seen_writes), 64'(exp_writes));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    initial begin
        int r;
        // Reset state
        drive_cycle(1, 0, 0, 8'h00);
        check_status("reset");

        // Single word, little-endian assembly
        do_start(0);
        check("start_busy", 64'(o_busy), 64'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        check("w1_value", 64'(o_w_data), 64'h12345678);
        check_status("single");

        // Halt-terminated load
        drive_cycle(1, 0, 0, 8'h00);
        do_start(0);
        send_word(32'h1); send_word(32'h2); send_word(HALT);
        check_status("halt");
        check("halt_done", 64'(o_done), 64'd1);
        check("halt_cnt", 64'(o_word_count), 64'd3);

        // Restart from DONE with a byte coinciding with start
        do_start(1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("restart_val", 64'(o_w_data), 64'hDDCCBBAA);
        check("restart_adr", 64'(o_w_addr), 64'd0);
        check_status("restart");

        // Start during LOAD is ignored
        send_byte(8'h11);
        drive_cycle(0, 1, 0, 8'h00);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("ign_val", 64'(o_w_data), 64'h44332211);
        check("ign_adr", 64'(o_w_addr), 64'd1);
        check_status("ignstart");

        // Reset mid-word discards it; bytes without start never write
        drive_cycle(1, 0, 0, 8'h00);
        do_start(0);
        send_byte(8'h01); send_byte(8'h02);
        drive_cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        check_status("midreset");

        // Address limit reached without a terminator
        do_start(0);
        for (int i = 0; i < N_ADDRESS; i++) send_word(rand_word());
        check_status("full");
        check("full_flag", 64'(o_full), 64'd1);
        check("full_cnt", 64'(o_word_count), 64'd64);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        check_status("fullafter");

        // Terminator at the last address wins over the limit
        do_start(0);
        for (int i = 0; i < N_ADDRESS - 1; i++) send_word(rand_word());
        send_word(HALT);
        check_status("haltlast");
        check("haltlast_full", 64'(o_full), 64'd0);

        // Randomized mix of starts, resets, bytes and words
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       drive_cycle(1, 0, 0, 8'h00);
            else if (r < 12) do_start($urandom_range(0, 1) == 1);
            else if (r < 18) check_status("rand");
            else if (r < 22) drive_cycle(0, 1, 1, 8'($urandom));
            else if (r < 40) send_byte(8'($urandom));
            else if (r < 46) send_word(HALT);
            else             send_word(rand_word());
        end
        check_status("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
